muxer_blank_n: RTL and testbench
================================

// Module: muxer_blank_n
// PURPOSE
//  Parametrised registered N:1 signal router with a break-before-make blanking interval.
//  Channel changes are not applied instantly. After a select change the output is frozen
//  for a programmable number of cycles, then the new channel is routed.
//  Sits between the lock-in/PID signal sources and the DAC/PID-input selection registers,
//  so that live re-routing does not inject a one-sample step from an unrelated source.
// PARAMETERS
//  RES    14  data width of each channel and of out
//  N      32  number of input channels (2..256)
//  SEL_W   5  select width; must satisfy 2**SEL_W >= N
//  CNT_W  16  width of hold_cyc and of the blanking counter
// PORTS
//  clk       in   1          system clock
//  rstn      in   1          asynchronous active-low reset
//  sel       in   SEL_W      requested channel
//  in_bus    in   N*RES      flattened inputs; channel k = in_bus[k*RES +: RES]
//  hold_cyc  in   CNT_W      blanking length in cycles; 0 = immediate switch
//  out       out  RES        routed data (registered)
//  busy      out  1          high while blanking
//  sel_act   out  SEL_W      channel currently routed to out
//  sw_cnt    out  16         count of completed channel changes; wraps at 2**16
// BEHAVIOUR
//  - Reset (rstn=0, asynchronous): out=0, busy=0, sel_act=0, sw_cnt=0, state=RUN, counter=0.
//  - Channel value v(c) = in_bus[c] for c<N. For c>=N (out-of-range), v(c)=0; such a c is still a legal channel.
//  - State RUN:
//    - Every edge: out <= v(sel_act). Latency is 1 cycle from in_bus to out.
//    - If sel != sel_act and hold_cyc == 0: at the same edge sel_act <= sel, out <= v(sel), sw_cnt++. busy stays 0.
//    - If sel != sel_act and hold_cyc != 0: at the sampling edge T0 go to BLANK.
//      Latch pend <= sel and cnt <= hold_cyc-1; set busy <= 1; out holds its previous value.
//  - State BLANK:
//    - out is frozen. sel_act is unchanged.
//    - If sel != pend: pend <= sel, and cnt reloads from the hold_cyc value latched at entry (retrigger).
//    - Else if cnt != 0: cnt--.
//    - Else (cnt == 0):
//      - sel_act <= pend, out <= v(pend), busy <= 0, state <= RUN.
//      - sw_cnt increments only if pend != the old sel_act.
//  - Timing: with a steady sel, busy is high for exactly hold_cyc cycles (edges T0..T0+hold_cyc-1).
//    The new data appears at edge T0+hold_cyc.
//  - hold_cyc is sampled only on BLANK entry; changes during BLANK have no effect until the next entry.
//  - If sel returns to sel_act during BLANK, blanking still completes and the output resumes on the same channel.
//    sw_cnt does not change in this case.
//  - In RUN, sel changing on consecutive cycles with hold_cyc=0 switches on every cycle; each switch counts.
//  - Reset asserted mid-BLANK aborts to the reset state. The pending select is discarded.
//  - sw_cnt wraps from 16'hFFFF to 16'h0000 with no flag.
// CONFIGURATION
//  - MUXER_BLANK_ZERO_EN undefined: during BLANK, out holds the last routed sample.
//  - MUXER_BLANK_ZERO_EN defined:
//    - At edge T0 out <= 0, and it stays 0 for the whole BLANK period.
//    - The hold_cyc=0 path is identical in both builds.
//    - busy, sel_act and sw_cnt behave identically in both builds.
// TESTING
//  1. Reset, then drive in_bus channel k = k+100 with sel=3, hold_cyc=0 -> out=103 one cycle after sel is applied;
//     sel_act=3; sw_cnt=1; busy=0 throughout.
//  2. sel 3->7 with hold_cyc=5 -> busy high for exactly 5 cycles with out=103 (0 under MUXER_BLANK_ZERO_EN);
//     on the 6th edge out=107, sel_act=7, sw_cnt+1.
//  3. hold_cyc=4; sel 7->9, then 9->12 after 2 cycles -> counter retriggers; busy stays high 6 cycles total;
//     final out=112, sw_cnt+1 (not +2).
//  4. hold_cyc=4; sel 12->2, then back to 12 after 1 cycle -> busy for 5 cycles;
//     out resumes at 112; sel_act=12; sw_cnt unchanged.
//  5. N=20, sel=25, hold_cyc=0 -> out=0, sel_act=25. Then pull rstn low mid-BLANK (sel=4, hold_cyc=10):
//     out, busy, sel_act and sw_cnt are 0 immediately, with no clock edge needed.
//  6. Issue 65536 switches with hold_cyc=0 -> sw_cnt wraps to 0; routing is unaffected.

Source files
------------

// File: rtl/muxer_blank_n.sv
// -----------------------------------------------------------------------------
// muxer_blank_n
//   Registered N:1 signal router with a break-before-make blanking interval.
//   After a select change the output is frozen for hold_cyc cycles, then the
//   new channel is routed. hold_cyc == 0 switches at the sampling edge.
//
// Ports
//   clk       in   1          system clock
//   rstn      in   1          asynchronous active-low reset
//   sel       in   SEL_W      requested channel
//   in_bus    in   N*RES      flattened inputs, channel k = in_bus[k*RES +: RES]
//   hold_cyc  in   CNT_W      blanking length in cycles (0 = immediate switch)
//   out       out  RES        routed data (registered)
//   busy      out  1          high while blanking
//   sel_act   out  SEL_W      channel currently routed to out
//   sw_cnt    out  16         completed channel changes, wraps at 2**16
//
// Build option
//   MUXER_BLANK_ZERO_EN  when defined, out is forced to 0 for the whole
//                        blanking period instead of holding the last sample.
// -----------------------------------------------------------------------------
module muxer_blank_n #(
    parameter int unsigned RES   = 14,
    parameter int unsigned N     = 32,
    parameter int unsigned SEL_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*RES-1:0]   in_bus,
    input  logic [CNT_W-1:0]   hold_cyc,
    output logic [RES-1:0]     out,
    output logic               busy,
    output logic [SEL_W-1:0]   sel_act,
    output logic [15:0]        sw_cnt
);

    typedef enum logic {StRun, StBlank} state_e;

    state_e             r_state;
    logic [SEL_W-1:0]   r_pend;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_hold;
    logic [RES-1:0]     r_out;
    logic               r_busy;
    logic [SEL_W-1:0]   r_sel_act;
    logic [15:0]        r_sw_cnt;

    logic [RES-1:0]     w_v_act;
    logic [RES-1:0]     w_v_sel;
    logic [RES-1:0]     w_v_pend;

    // Selects at or above N are legal channels that read as zero.
    function automatic logic [RES-1:0] chan_val(input logic [N*RES-1:0] bus,
                                                input logic [SEL_W-1:0] c);
        logic [RES-1:0] v;
        v = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (c == SEL_W'(k)) begin
                v = bus[k*RES +: RES];
            end
        end
        return v;
    endfunction

    always_comb begin
        w_v_act  = chan_val(in_bus, r_sel_act);
        w_v_sel  = chan_val(in_bus, sel);
        w_v_pend = chan_val(in_bus, r_pend);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= StRun;
            r_pend    <= '0;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_out     <= '0;
            r_busy    <= 1'b0;
            r_sel_act <= '0;
            r_sw_cnt  <= '0;
        end else begin
            case (r_state)
                StRun: begin
                    if (sel != r_sel_act) begin
                        if (hold_cyc == '0) begin
                            r_sel_act <= sel;
                            r_out     <= w_v_sel;
                            r_sw_cnt  <= r_sw_cnt + 16'd1;
                        end else begin
                            // Entry edge counts as the first blanked cycle.
                            r_state <= StBlank;
                            r_pend  <= sel;
                            r_hold  <= hold_cyc;
                            r_cnt   <= hold_cyc - CNT_W'(1);
                            r_busy  <= 1'b1;
`ifdef MUXER_BLANK_ZERO_EN
                            r_out   <= '0;
`endif
                        end
                    end else begin
                        r_out <= w_v_act;
                    end
                end
                StBlank: begin
                    if (sel != r_pend) begin
                        // Retrigger: restart the full interval from the latched length.
                        r_pend <= sel;
                        r_cnt  <= r_hold - CNT_W'(1);
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state   <= StRun;
                        r_sel_act <= r_pend;
                        r_out     <= w_v_pend;
                        r_busy    <= 1'b0;
                        // Returning to the original channel is not a switch.
                        if (r_pend != r_sel_act) begin
                            r_sw_cnt <= r_sw_cnt + 16'd1;
                        end
                    end
                end
                default: r_state <= StRun;
            endcase
        end
    end

    assign out     = r_out;
    assign busy    = r_busy;
    assign sel_act = r_sel_act;
    assign sw_cnt  = r_sw_cnt;

endmodule

// File: tb/tb_muxer_blank_n.sv
// -----------------------------------------------------------------------------
// tb_muxer_blank_n
//   Scoreboard bench for muxer_blank_n. The stimulus process drives inputs on
//   the falling edge and pushes the reference model's prediction for the next
//   rising edge; the monitor pops one entry after each rising edge (or right
//   after an asynchronous reset) and compares all outputs.
// -----------------------------------------------------------------------------
module tb_muxer_blank_n;

    localparam int unsigned RES   = 14;
    localparam int unsigned N     = 20;
    localparam int unsigned SEL_W = 5;
    localparam int unsigned CNT_W = 16;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic [SEL_W-1:0]   sel = '0;
    logic [N*RES-1:0]   in_bus = '0;
    logic [CNT_W-1:0]   hold_cyc = '0;
    logic [RES-1:0]     out;
    logic               busy;
    logic [SEL_W-1:0]   sel_act;
    logic [15:0]        sw_cnt;

    always #5 clk = ~clk;

    muxer_blank_n #(
        .RES   (RES),
        .N     (N),
        .SEL_W (SEL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .sel      (sel),
        .in_bus   (in_bus),
        .hold_cyc (hold_cyc),
        .out      (out),
        .busy     (busy),
        .sel_act  (sel_act),
        .sw_cnt   (sw_cnt)
    );

    typedef struct packed {
        logic [RES-1:0]   out;
        logic             busy;
        logic [SEL_W-1:0] act;
        logic [15:0]      sw;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Channel contents as seen by the bench.
    logic [RES-1:0] ch [N];

    // Reference model: a switch request opens a blanking window whose end is
    // an absolute edge number (deadline); re-requests move the deadline.
    bit             m_blank;
    int             m_act;
    int             m_pend;
    int             m_hlat;
    longint         m_edge = 0;
    longint         m_deadline;
    logic [RES-1:0] m_out;
    bit             m_busy;
    logic [15:0]    m_sw;

    function automatic logic [RES-1:0] ref_val(input int c);
        return (c < int'(N)) ? ch[c] : '0;
    endfunction

    task automatic model_reset();
        m_blank = 1'b0;
        m_act   = 0;
        m_pend  = 0;
        m_out   = '0;
        m_busy  = 1'b0;
        m_sw    = '0;
    endtask

    task automatic model_edge(input int s, input int h);
        m_edge++;
        if (!m_blank) begin
            if (s != m_act) begin
                if (h == 0) begin
                    m_act = s;
                    m_out = ref_val(s);
                    m_sw  = m_sw + 16'd1;
                end else begin
                    m_blank    = 1'b1;
                    m_busy     = 1'b1;
                    m_pend     = s;
                    m_hlat     = h;
                    m_deadline = m_edge + longint'(h);
`ifdef MUXER_BLANK_ZERO_EN
                    m_out      = '0;
`endif
                end
            end else begin
                m_out = ref_val(m_act);
            end
        end else if (s != m_pend) begin
            m_pend     = s;
            m_deadline = m_edge + longint'(m_hlat);
        end else if (m_edge == m_deadline) begin
            if (m_pend != m_act) m_sw = m_sw + 16'd1;
            m_act   = m_pend;
            m_out   = ref_val(m_pend);
            m_busy  = 1'b0;
            m_blank = 1'b0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.out  = m_out;
        e.busy = m_busy;
        e.act  = SEL_W'(m_act);
        e.sw   = m_sw;
        exp_q.push_back(e);
    endtask

    task automatic drive_bus();
        for (int k = 0; k < int'(N); k++) in_bus[k*RES +: RES] = ch[k];
    endtask

    task automatic step(input int s, input int h);
        @(negedge clk);
        rstn     = 1'b1;
        sel      = SEL_W'(s);
        hold_cyc = CNT_W'(h);
        drive_bus();
        model_edge(s, h);
        push_exp();
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rstn = 1'b0;
        model_reset();
        push_exp();
    endtask

    // Reset between edges: the monitor checks it before the next rising edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        model_reset();
        push_exp();
    endtask

    // Monitor
    initial begin
        forever begin
            @(posedge clk or negedge rstn);
            #1;
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                n_checks++;
                if (out === mon_e.out && busy === mon_e.busy &&
                    sel_act === mon_e.act && sw_cnt === mon_e.sw) begin
                    n_pass++;
                end else begin
                    $display("FAIL outputs@%0t: got out=%0d busy=%0b sel_act=%0d sw_cnt=%0d, want out=%0d busy=%0b sel_act=%0d sw_cnt=%0d",
                             $time, out, busy, sel_act, sw_cnt,
                             mon_e.out, mon_e.busy, mon_e.act, mon_e.sw);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int s;
        int h;
        model_reset();
        for (int k = 0; k < int'(N); k++) ch[k] = RES'(k + 100);
        repeat (3) reset_cycle();

        // Immediate switch to channel 3.
        repeat (3) step(3, 0);
        // Blanked switch 3 -> 7, five cycles.
        repeat (8) step(7, 5);
        // Retrigger 7 -> 9 -> 12.
        repeat (2) step(9, 4);
        repeat (8) step(12, 4);
        // Excursion 12 -> 2 -> 12: no switch counted.
        step(2, 4);
        repeat (8) step(12, 4);
        // Out-of-range channel, then reset in the middle of blanking.
        repeat (3) step(25, 0);
        repeat (3) step(4, 10);
        async_reset();
        repeat (2) reset_cycle();

        // Counter wrap: 65536 immediate switches.
        for (int i = 0; i < 65536; i++) step((i % 2 == 0) ? 1 : 2, 0);
        repeat (3) step(2, 0);
        repeat (3) step(19, 0);

        // Randomised phase.
        s = 19;
        h = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) s = int'($urandom_range(0, 31));
            if ($urandom_range(0, 7) == 0) h = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < 3; j++) ch[$urandom_range(0, N - 1)] = RES'($urandom_range(0, 16383));
            end
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
                reset_cycle();
            end
            step(s, h);
        end

        repeat (2) @(posedge clk);
        #2;
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
